// File: rtl/ftoi_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ftoi_pipe
//  Purpose  : Three-stage pipelined IEEE-754 binary32 to signed int32
//             converter. Rounds to nearest with ties away from zero and
//             saturates out-of-range inputs. NaN converts to 0x7FFFFFFF.
//  Ports    : clk        clock, rising edge
//             rst        synchronous active-high reset
//             in_valid   operand x valid
//             in_ready   unit can accept x this cycle
//             x          binary32 operand {sign, exp[7:0], frac[22:0]}
//             out_valid  result y valid
//             out_ready  consumer accepts y this cycle
//             y          signed two's-complement result
//             flags      {overflow, inexact}, only when FTOI_FLAGS_EN is
//                        defined
//  Options  : FTOI_FLAGS_EN - adds the flags output and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module ftoi_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
`ifdef FTOI_FLAGS_EN
   ,
   output logic [1:0]  flags
`endif
);

   localparam logic [2:0] CLS_ZERO = 3'd0;
   localparam logic [2:0] CLS_HALF = 3'd1;
   localparam logic [2:0] CLS_NORM = 3'd2;
   localparam logic [2:0] CLS_MIN  = 3'd3;
   localparam logic [2:0] CLS_SAT  = 3'd4;

   // Whole pipeline advances together; a stalled output freezes every stage.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------------------------------------------------------- S1 ----
   logic [7:0] x_exp;
   logic       x_nan;
   logic [2:0] x_cls;

   assign x_exp = x[30:23];
   assign x_nan = (x_exp == 8'hFF) && (x[22:0] != 23'd0);

   always_comb begin
      x_cls = CLS_SAT;
      if (x == 32'hCF00_0000)
         x_cls = CLS_MIN;          // -2^31 is the only representable e=158
      else if (x_exp < 8'd126)
         x_cls = CLS_ZERO;
      else if (x_exp == 8'd126)
         x_cls = CLS_HALF;
      else if (x_exp <= 8'd157)
         x_cls = CLS_NORM;
   end

   logic        s1_valid;
   logic        s1_sign;
   logic [7:0]  s1_exp;
   logic [23:0] s1_man;
   logic [2:0]  s1_cls;
`ifdef FTOI_FLAGS_EN
   logic        s1_nz;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         // NaN saturates positive whatever its sign bit says.
         s1_sign  <= x[31] & ~x_nan;
         s1_exp   <= x_exp;
         s1_man   <= {1'b1, x[22:0]};
         s1_cls   <= x_cls;
`ifdef FTOI_FLAGS_EN
         s1_nz    <= (x[30:0] != 31'd0);
`endif
      end
   end

   // ---------------------------------------------------------------- S2 ----
   // m * 2^(e-150) expressed with 32 fraction bits is m << (e-118).
   // For NORM (127..157) the shift is 9..39, so 64 bits hold it exactly:
   // bits [63:32] are the integer part, bit 31 is the guard bit.
   logic [5:0]  sh_amt;
   logic [63:0] man_ext;
   logic [32:0] aligned;

   assign sh_amt  = 6'(s1_exp - 8'd118);
   assign man_ext = {40'd0, s1_man};
   assign aligned = 33'((man_ext << sh_amt) >> 31);

`ifdef FTOI_FLAGS_EN
   logic [30:0] aligned_lo;
   logic        s1_inexact;
   assign aligned_lo = 31'(man_ext << sh_amt);

   always_comb begin
      s1_inexact = 1'b0;
      case (s1_cls)
         CLS_ZERO: s1_inexact = s1_nz;
         CLS_HALF: s1_inexact = 1'b1;
         CLS_NORM: s1_inexact = aligned[0] | (|aligned_lo);
         default:  s1_inexact = 1'b0;
      endcase
   end
`endif

   logic        s2_valid;
   logic        s2_sign;
   logic [2:0]  s2_cls;
   logic [31:0] s2_int;
   logic        s2_guard;
`ifdef FTOI_FLAGS_EN
   logic        s2_inexact;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_cls   <= s1_cls;
         s2_int   <= aligned[32:1];
         s2_guard <= aligned[0];
`ifdef FTOI_FLAGS_EN
         s2_inexact <= s1_inexact;
`endif
      end
   end

   // ---------------------------------------------------------------- S3 ----
   // Ties away from zero only needs the guard bit; sticky never matters.
   logic [31:0] mag;
   logic [31:0] res;

   assign mag = s2_int + {31'd0, s2_guard};

   always_comb begin
      res = 32'd0;
      case (s2_cls)
         CLS_ZERO: res = 32'd0;
         CLS_HALF: res = s2_sign ? 32'hFFFF_FFFF : 32'd1;
         CLS_NORM: res = s2_sign ? (32'd0 - mag) : mag;
         CLS_MIN:  res = 32'h8000_0000;
         default:  res = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= 32'd0;
`ifdef FTOI_FLAGS_EN
         flags     <= 2'b00;
`endif
      end else if (adv) begin
         out_valid <= s2_valid;
         // Bubbles present a clean zero rather than stale data.
         y         <= s2_valid ? res : 32'd0;
`ifdef FTOI_FLAGS_EN
         flags     <= s2_valid ? {(s2_cls == CLS_SAT), s2_inexact} : 2'b00;
`endif
      end
   end

endmodule
`default_nettype wire
